// File: rtl/eth_cmd_regs.sv
// Transmit-side command register file: holds MAC/ARP/UDP frame parameters and issues send pulses.
// Optional combinational readback port enabled by defining CMD_READBACK_EN.
module eth_cmd_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    input  logic        i_cmd_wr,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [1:0]  o_operation,
    output logic [47:0] o_SHA,
    output logic [31:0] o_SPA,
    output logic [47:0] o_THA,
    output logic [31:0] o_TPA,
    output logic [31:0] o_src_ip,
    output logic [31:0] o_dst_ip,
    output logic [15:0] o_src_port,
    output logic [15:0] o_dst_port,
    output logic [15:0] o_udp_data_len,
    output logic [1:0]  o_send_packet
`ifdef CMD_READBACK_EN
    ,
    input  logic [7:0]  i_rd_addr,
    output logic [31:0] o_rd_data
`endif
);

    localparam logic [7:0] A_SEND    = 8'h02;
    localparam logic [7:0] A_DMAC_HI = 8'h04;
    localparam logic [7:0] A_DMAC_LO = 8'h05;
    localparam logic [7:0] A_SMAC_HI = 8'h06;
    localparam logic [7:0] A_SMAC_LO = 8'h07;
    localparam logic [7:0] A_OPER    = 8'h08;
    localparam logic [7:0] A_SHA_HI  = 8'h09;
    localparam logic [7:0] A_SHA_LO  = 8'h0A;
    localparam logic [7:0] A_SPA     = 8'h0B;
    localparam logic [7:0] A_THA_HI  = 8'h0C;
    localparam logic [7:0] A_THA_LO  = 8'h0D;
    localparam logic [7:0] A_TPA     = 8'h0E;
    localparam logic [7:0] A_SRC_IP  = 8'h10;
    localparam logic [7:0] A_DST_IP  = 8'h11;
    localparam logic [7:0] A_SPORT   = 8'h12;
    localparam logic [7:0] A_DPORT   = 8'h13;
    localparam logic [7:0] A_UDP_LEN = 8'h14;

    localparam logic [47:0] RST_DST_MAC = 48'h0C54A5312485;
    localparam logic [47:0] RST_SRC_MAC = 48'h0023543C471B;
    localparam logic [1:0]  RST_OPER    = 2'd1;
    localparam logic [31:0] RST_SRC_IP  = 32'h0A000064;
    localparam logic [31:0] RST_DST_IP  = 32'h0A000002;
    localparam logic [15:0] RST_SPORT   = 16'h1420;
    localparam logic [15:0] RST_DPORT   = 16'h0883;
    localparam logic [15:0] RST_UDP_LEN = 16'h0400;

    logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
    logic [47:0] sha_q, sha_d, tha_q, tha_d;
    logic [31:0] spa_q, spa_d, tpa_q, tpa_d, src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    logic [15:0] src_port_q, src_port_d, dst_port_q, dst_port_d, udp_len_q, udp_len_d;
    logic [1:0]  oper_q, oper_d, send_q, send_d;

    // Next-state decode of a single write; HI/LO writes only touch their own slice.
    always_comb begin
        dst_mac_d  = dst_mac_q;
        src_mac_d  = src_mac_q;
        oper_d     = oper_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        tha_d      = tha_q;
        tpa_d      = tpa_q;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        src_port_d = src_port_q;
        dst_port_d = dst_port_q;
        udp_len_d  = udp_len_q;
        send_d     = 2'b00;
        if (i_cmd_wr) begin
            case (i_cmd_addr)
                A_SEND: begin
                    case (i_cmd_data[1:0])
                        2'b01, 2'b10: send_d = i_cmd_data[1:0];
                        default:      send_d = 2'b00;
                    endcase
                end
                A_DMAC_HI: dst_mac_d[47:16] = i_cmd_data;
                A_DMAC_LO: dst_mac_d[15:0]  = i_cmd_data[15:0];
                A_SMAC_HI: src_mac_d[47:16] = i_cmd_data;
                A_SMAC_LO: src_mac_d[15:0]  = i_cmd_data[15:0];
                A_OPER:    oper_d           = i_cmd_data[1:0];
                A_SHA_HI:  sha_d[47:16]     = i_cmd_data;
                A_SHA_LO:  sha_d[15:0]      = i_cmd_data[15:0];
                A_SPA:     spa_d            = i_cmd_data;
                A_THA_HI:  tha_d[47:16]     = i_cmd_data;
                A_THA_LO:  tha_d[15:0]      = i_cmd_data[15:0];
                A_TPA:     tpa_d            = i_cmd_data;
                A_SRC_IP:  src_ip_d         = i_cmd_data;
                A_DST_IP:  dst_ip_d         = i_cmd_data;
                A_SPORT:   src_port_d       = i_cmd_data[15:0];
                A_DPORT:   dst_port_d       = i_cmd_data[15:0];
                A_UDP_LEN: udp_len_d        = i_cmd_data[15:0];
                default:   send_d           = 2'b00;
            endcase
        end else begin
            send_d = 2'b00;
        end
    end

    // Register state with synchronous reset to the default frame parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_mac_q  <= RST_DST_MAC;
            src_mac_q  <= RST_SRC_MAC;
            oper_q     <= RST_OPER;
            sha_q      <= 48'h0;
            spa_q      <= 32'h0;
            tha_q      <= 48'h0;
            tpa_q      <= 32'h0;
            src_ip_q   <= RST_SRC_IP;
            dst_ip_q   <= RST_DST_IP;
            src_port_q <= RST_SPORT;
            dst_port_q <= RST_DPORT;
            udp_len_q  <= RST_UDP_LEN;
            send_q     <= 2'b00;
        end else begin
            dst_mac_q  <= dst_mac_d;
            src_mac_q  <= src_mac_d;
            oper_q     <= oper_d;
            sha_q      <= sha_d;
            spa_q      <= spa_d;
            tha_q      <= tha_d;
            tpa_q      <= tpa_d;
            src_ip_q   <= src_ip_d;
            dst_ip_q   <= dst_ip_d;
            src_port_q <= src_port_d;
            dst_port_q <= dst_port_d;
            udp_len_q  <= udp_len_d;
            send_q     <= send_d;
        end
    end

    assign o_dst_mac      = dst_mac_q;
    assign o_src_mac      = src_mac_q;
    assign o_operation    = oper_q;
    assign o_SHA          = sha_q;
    assign o_SPA          = spa_q;
    assign o_THA          = tha_q;
    assign o_TPA          = tpa_q;
    assign o_src_ip       = src_ip_q;
    assign o_dst_ip       = dst_ip_q;
    assign o_src_port     = src_port_q;
    assign o_dst_port     = dst_port_q;
    assign o_udp_data_len = udp_len_q;
    assign o_send_packet  = send_q;

`ifdef CMD_READBACK_EN
    // Combinational readback using the write map; SEND and holes read zero.
    always_comb begin
        o_rd_data = 32'h0;
        case (i_rd_addr)
            A_DMAC_HI: o_rd_data = dst_mac_q[47:16];
            A_DMAC_LO: o_rd_data = {16'h0, dst_mac_q[15:0]};
            A_SMAC_HI: o_rd_data = src_mac_q[47:16];
            A_SMAC_LO: o_rd_data = {16'h0, src_mac_q[15:0]};
            A_OPER:    o_rd_data = {30'h0, oper_q};
            A_SHA_HI:  o_rd_data = sha_q[47:16];
            A_SHA_LO:  o_rd_data = {16'h0, sha_q[15:0]};
            A_SPA:     o_rd_data = spa_q;
            A_THA_HI:  o_rd_data = tha_q[47:16];
            A_THA_LO:  o_rd_data = {16'h0, tha_q[15:0]};
            A_TPA:     o_rd_data = tpa_q;
            A_SRC_IP:  o_rd_data = src_ip_q;
            A_DST_IP:  o_rd_data = dst_ip_q;
            A_SPORT:   o_rd_data = {16'h0, src_port_q};
            A_DPORT:   o_rd_data = {16'h0, dst_port_q};
            A_UDP_LEN: o_rd_data = {16'h0, udp_len_q};
            default:   o_rd_data = 32'h0;
        endcase
    end
`endif

endmodule

// File: tb/tb_eth_cmd_regs.sv
// Self-checking bench for eth_cmd_regs: a reference model pushes expected register
// snapshots into a queue as each write is driven; they are popped and compared after the edge.
module tb_eth_cmd_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  i_cmd_addr = 8'h00;
    logic [31:0] i_cmd_data = 32'h0;
    logic        i_cmd_wr = 1'b0;
    logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
    logic [1:0]  o_operation, o_send_packet;
    logic [31:0] o_SPA, o_TPA, o_src_ip, o_dst_ip;
    logic [15:0] o_src_port, o_dst_port, o_udp_data_len;
`ifdef CMD_READBACK_EN
    logic [7:0]  i_rd_addr = 8'h00;
    logic [31:0] o_rd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [1:0]  oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_len;
        logic [1:0]  send;
    } snap_t;

    snap_t m;
    snap_t exp_q[$];

    eth_cmd_regs dut (
        .clk(clk), .rst(rst),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_wr(i_cmd_wr),
        .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_operation(o_operation),
        .o_SHA(o_SHA), .o_SPA(o_SPA), .o_THA(o_THA), .o_TPA(o_TPA),
        .o_src_ip(o_src_ip), .o_dst_ip(o_dst_ip),
        .o_src_port(o_src_port), .o_dst_port(o_dst_port),
        .o_udp_data_len(o_udp_data_len), .o_send_packet(o_send_packet)
`ifdef CMD_READBACK_EN
        , .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic snap_t reset_snap();
        snap_t s;
        s.dst_mac = 48'h0C54A5312485; s.src_mac = 48'h0023543C471B; s.oper = 2'd1;
        s.sha = 48'h0; s.spa = 32'h0; s.tha = 48'h0; s.tpa = 32'h0;
        s.src_ip = 32'h0A000064; s.dst_ip = 32'h0A000002;
        s.src_port = 16'h1420; s.dst_port = 16'h0883; s.udp_len = 16'h0400;
        s.send = 2'b00;
        return s;
    endfunction

    function automatic snap_t model_step(input snap_t s, input logic r, input logic wr,
                                         input logic [7:0] a, input logic [31:0] d);
        snap_t n = s;
        n.send = 2'b00;
        if (r) return reset_snap();
        if (wr) begin
            case (a)
                8'h02: if (d[1:0] == 2'b01 || d[1:0] == 2'b10) n.send = d[1:0];
                8'h04: n.dst_mac = {d, s.dst_mac[15:0]};
                8'h05: n.dst_mac = {s.dst_mac[47:16], d[15:0]};
                8'h06: n.src_mac = {d, s.src_mac[15:0]};
                8'h07: n.src_mac = {s.src_mac[47:16], d[15:0]};
                8'h08: n.oper = d[1:0];
                8'h09: n.sha = {d, s.sha[15:0]};
                8'h0A: n.sha = {s.sha[47:16], d[15:0]};
                8'h0B: n.spa = d;
                8'h0C: n.tha = {d, s.tha[15:0]};
                8'h0D: n.tha = {s.tha[47:16], d[15:0]};
                8'h0E: n.tpa = d;
                8'h10: n.src_ip = d;
                8'h11: n.dst_ip = d;
                8'h12: n.src_port = d[15:0];
                8'h13: n.dst_port = d[15:0];
                8'h14: n.udp_len = d[15:0];
                default: n.send = 2'b00;
            endcase
        end
        return n;
    endfunction

    task automatic compare_next();
        snap_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check("dst_mac",  {16'h0, o_dst_mac},  {16'h0, e.dst_mac});
        check("src_mac",  {16'h0, o_src_mac},  {16'h0, e.src_mac});
        check("operation", {62'h0, o_operation}, {62'h0, e.oper});
        check("SHA",      {16'h0, o_SHA},      {16'h0, e.sha});
        check("SPA",      {32'h0, o_SPA},      {32'h0, e.spa});
        check("THA",      {16'h0, o_THA},      {16'h0, e.tha});
        check("TPA",      {32'h0, o_TPA},      {32'h0, e.tpa});
        check("src_ip",   {32'h0, o_src_ip},   {32'h0, e.src_ip});
        check("dst_ip",   {32'h0, o_dst_ip},   {32'h0, e.dst_ip});
        check("src_port", {48'h0, o_src_port}, {48'h0, e.src_port});
        check("dst_port", {48'h0, o_dst_port}, {48'h0, e.dst_port});
        check("udp_len",  {48'h0, o_udp_data_len}, {48'h0, e.udp_len});
        check("send",     {62'h0, o_send_packet},  {62'h0, e.send});
    endtask

    // One clock: drive inputs, push the modelled result, then compare after the edge.
    task automatic cycle(input logic r, input logic wr, input logic [7:0] a, input logic [31:0] d);
        rst = r; i_cmd_wr = wr; i_cmd_addr = a; i_cmd_data = d;
        m = model_step(m, r, wr, a, d);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        rst = 1'b0; i_cmd_wr = 1'b0;
        compare_next();
    endtask

`ifdef CMD_READBACK_EN
    function automatic logic [31:0] rd_model(input snap_t s, input logic [7:0] a);
        case (a)
            8'h04: return s.dst_mac[47:16];
            8'h05: return {16'h0, s.dst_mac[15:0]};
            8'h06: return s.src_mac[47:16];
            8'h07: return {16'h0, s.src_mac[15:0]};
            8'h08: return {30'h0, s.oper};
            8'h09: return s.sha[47:16];
            8'h0A: return {16'h0, s.sha[15:0]};
            8'h0B: return s.spa;
            8'h0C: return s.tha[47:16];
            8'h0D: return {16'h0, s.tha[15:0]};
            8'h0E: return s.tpa;
            8'h10: return s.src_ip;
            8'h11: return s.dst_ip;
            8'h12: return {16'h0, s.src_port};
            8'h13: return {16'h0, s.dst_port};
            8'h14: return {16'h0, s.udp_len};
            default: return 32'h0;
        endcase
    endfunction
`endif

    initial begin
        m = reset_snap();
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h00, 32'h0);
        check("rst_src_mac", {16'h0, o_src_mac}, 64'h0023543C471B);
        check("rst_dst_ip", {32'h0, o_dst_ip}, 64'h0A000002);
        check("rst_dst_port", {48'h0, o_dst_port}, 64'h0883);
        check("rst_udp_len", {48'h0, o_udp_data_len}, 64'h0400);
        check("rst_operation", {62'h0, o_operation}, 64'd1);
        check("rst_send", {62'h0, o_send_packet}, 64'd0);
        cycle(1'b0, 1'b0, 8'h00, 32'h0);

        cycle(1'b0, 1'b1, 8'h04, 32'hD8D38526);
        cycle(1'b0, 1'b1, 8'h05, 32'h0000C578);
        check("dst_mac_full", {16'h0, o_dst_mac}, 64'hD8D38526C578);
        cycle(1'b0, 1'b1, 8'h05, 32'h00001234);
        check("dst_mac_lo_only", {16'h0, o_dst_mac}, 64'hD8D385261234);

        cycle(1'b0, 1'b1, 8'h12, 32'hFFFFC350);
        check("src_port_trunc", {48'h0, o_src_port}, 64'hC350);
        cycle(1'b0, 1'b1, 8'h30, 32'hFFFFFFFF);

        cycle(1'b0, 1'b1, 8'h02, 32'h2);
        check("send_udp", {62'h0, o_send_packet}, 64'd2);
        cycle(1'b0, 1'b0, 8'h02, 32'h2);
        check("send_udp_end", {62'h0, o_send_packet}, 64'd0);
        cycle(1'b0, 1'b1, 8'h02, 32'h3);
        check("send_11_none", {62'h0, o_send_packet}, 64'd0);

        cycle(1'b0, 1'b1, 8'h02, 32'h1);
        check("b2b_first", {62'h0, o_send_packet}, 64'd1);
        cycle(1'b0, 1'b1, 8'h02, 32'h2);
        check("b2b_second", {62'h0, o_send_packet}, 64'd2);
        cycle(1'b0, 1'b0, 8'h00, 32'h0);
        check("b2b_idle", {62'h0, o_send_packet}, 64'd0);

        for (int i = 0; i < 40; i++)
            cycle(1'b0, 1'b1, 8'($urandom_range(0, 31)), $urandom);

`ifdef CMD_READBACK_EN
        for (int i = 0; i < 32; i++) begin
            i_rd_addr = 8'(i);
            #1;
            check("readback", {32'h0, o_rd_data}, {32'h0, rd_model(m, 8'(i))});
        end
`endif

        cycle(1'b0, 1'b1, 8'h10, 32'hC0A80001);
        cycle(1'b0, 1'b1, 8'h02, 32'h1);
        check("pre_rst_pulse", {62'h0, o_send_packet}, 64'd1);
        cycle(1'b1, 1'b0, 8'h00, 32'h0);
        check("rst_kills_pulse", {62'h0, o_send_packet}, 64'd0);
        check("rst_src_ip", {32'h0, o_src_ip}, 64'h0A000064);
`ifdef CMD_READBACK_EN
        i_rd_addr = 8'h10;
        #1;
        check("rd_src_ip", {32'h0, o_rd_data}, 64'h0A000064);
`endif
        cycle(1'b0, 1'b0, 8'h00, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_cmd_regs.md
Name: eth_cmd_regs

Overview:
- Transmit-side command register file for the Ethernet MAC/ARP/UDP subsystem.
- The NIOS-II writes frame parameters through a simple address/data/write strobe: MACs, ARP fields, IPs, ports and UDP payload length.
- The block holds these values and drives them continuously to the ARP and UDP frame generators.
- A write to the SEND register emits a one-cycle send request tagged with the packet type.

Parameters:
- None.

Ports:
- clk  in  1  transmit clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_cmd_addr  in  8  register address
- i_cmd_data  in  32  write data
- i_cmd_wr  in  1  write strobe, one write per asserted cycle
- o_dst_mac  out  48  Ethernet destination MAC
- o_src_mac  out  48  Ethernet source MAC
- o_operation  out  2  ARP operation (1 = request, 2 = reply)
- o_SHA  out  48  ARP sender hardware address
- o_SPA  out  32  ARP sender protocol address
- o_THA  out  48  ARP target hardware address
- o_TPA  out  32  ARP target protocol address
- o_src_ip  out  32  UDP/IP source address
- o_dst_ip  out  32  UDP/IP destination address
- o_src_port  out  16  UDP source port
- o_dst_port  out  16  UDP destination port
- o_udp_data_len  out  16  UDP payload length in bytes
- o_send_packet  out  2  send request: 01 = ARP, 10 = UDP, 00 = idle

Behaviour:
- Register map (addr: field, bits taken from i_cmd_data):
  - 0x02 SEND [1:0]
  - 0x04 dst_mac[47:16] = data[31:0]; 0x05 dst_mac[15:0] = data[15:0]
  - 0x06 src_mac[47:16]; 0x07 src_mac[15:0]
  - 0x08 operation = data[1:0]
  - 0x09 SHA[47:16]; 0x0A SHA[15:0]; 0x0B SPA
  - 0x0C THA[47:16]; 0x0D THA[15:0]; 0x0E TPA
  - 0x10 src_ip; 0x11 dst_ip
  - 0x12 src_port = data[15:0]; 0x13 dst_port = data[15:0]; 0x14 udp_data_len = data[15:0]
- Writes occur when i_cmd_wr=1 at a clock edge; the new value is visible on the output the cycle after.
- A HI or LO write changes only its own slice; the other slice holds.
- Unused data bits are ignored.
- Writes to unmapped addresses are ignored with no side effects.
- Reset values:
  - dst_mac 0x0C54A5312485, src_mac 0x0023543C471B
  - operation 1
  - SHA, SPA, THA, TPA all 0
  - src_ip 0x0A000064, dst_ip 0x0A000002
  - src_port 0x1420, dst_port 0x0883, udp_data_len 0x0400
  - o_send_packet 0
- SEND write with data[1:0] = 01 or 10: o_send_packet equals that value for exactly one cycle (the cycle after the write), then returns to 00.
- SEND write with data[1:0] = 00 or 11: no pulse.
- Back-to-back SEND writes produce back-to-back pulses, each carrying its own type. No queuing and no busy interlock; the downstream generator debounces.
- Parameters written in cycles before a SEND are guaranteed visible when the pulse is high.
- Reset asserted during a pulse clears o_send_packet on the same edge and restores all registers to their reset values.
- No reads in the base configuration.

Optional Feature:
- Macro CMD_READBACK_EN.
- When defined, adds port i_rd_addr (in, 8) and o_rd_data (out, 32).
  - o_rd_data is a combinational readback of the register at i_rd_addr, zero-extended, using the same map.
  - SEND reads 0; unmapped addresses read 0.
- When undefined, these ports and the read mux do not exist; write behaviour is identical either way.

Test Plan:
- Reset -> o_src_mac=0x0023543C471B, o_dst_ip=0x0A000002, o_dst_port=0x0883, o_udp_data_len=0x0400, o_operation=1, o_send_packet=0.
- Write 0x04=0xD8D38526, 0x05=0x0000C578 -> o_dst_mac=0xD8D38526C578 one cycle after the second write. A further write 0x05=0x1234 leaves [47:16] intact.
- Write 0x12=0xFFFFC350 -> o_src_port=0xC350. Write 0x30 with i_cmd_wr=1 -> no output changes.
- Write 0x02=0x2 -> o_send_packet=10 for exactly one cycle, then 00. Write 0x02=0x3 -> remains 00.
- Write 0x02=1 and 0x02=2 on consecutive cycles -> o_send_packet sequence 01, 10, 00.
- Assert rst in the cycle o_send_packet=01, after modifying src_ip -> next cycle o_send_packet=0 and src_ip=0x0A000064. With CMD_READBACK_EN: i_rd_addr=0x10 reads 0x0A000064.
